// File: rtl/soc_system_pio_arb_pkg.sv
// Shared definitions for the two-master PIO arbiter.
//   state_e    : arbiter FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   NUM_REQ    : number of requesting masters
//   DEF_*      : default data, address and contention-counter widths
package soc_system_pio_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/soc_system_pio_arb_rr.sv
// Two-way round-robin selector.
//   req         : request vector, bit X = master X chipselect
//   last_grant  : index of the master granted most recently
//   grant_valid : at least one request is pending
//   grant_idx   : winning master index
module soc_system_pio_arb_rr
  import soc_system_pio_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic               grant_valid,
  output logic               grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    // On contention the master that was not served last time wins.
    if (&req) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/soc_system_pio_arbiter.sv
// Arbitrates two Avalon-style masters onto a single zero-latency PIO slave.
// Each grant occupies three cycles: IDLE (arbitrate, register request),
// ACCESS (pio_chipselect high, read data captured) and DONE (waitrequest
// low for the granted master).
//   clk, reset                 : clock, synchronous active-high reset
//   mX_address/_chipselect/_write_n/_writedata : master X request
//   mX_readdata                : registered read data for master X
//   mX_waitrequest             : stall, low for one cycle at completion
//   pio_address/_chipselect/_write_n/_writedata : registered slave request
//   pio_readdata               : combinational slave read data
//   contention_cnt             : saturating count of contended IDLE cycles
module soc_system_pio_arbiter
  import soc_system_pio_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_chipselect,
  input  logic              m0_write_n,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_chipselect,
  input  logic              m1_write_n,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [DATA_W-1:0] pio_writedata,
  input  logic [DATA_W-1:0] pio_readdata,
  output logic [CNT_W-1:0]  contention_cnt
);

  state_e              state_q;
  logic                grant_q;
  logic                last_grant_q;
  logic [ADDR_W-1:0]   pio_address_q;
  logic                pio_chipselect_q;
  logic                pio_write_n_q;
  logic [DATA_W-1:0]   pio_writedata_q;
  logic [DATA_W-1:0]   m0_readdata_q;
  logic [DATA_W-1:0]   m1_readdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [NUM_REQ-1:0]  req;
  logic                grant_valid;
  logic                grant_idx;
  logic [ADDR_W-1:0]   sel_address_d;
  logic                sel_write_n_d;
  logic [DATA_W-1:0]   sel_writedata_d;

  assign req = {m1_chipselect, m0_chipselect};

  soc_system_pio_arb_rr u_rr (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Request fields of whichever master wins this cycle.
  always_comb begin
    sel_address_d   = grant_idx ? m1_address   : m0_address;
    sel_write_n_d   = grant_idx ? m1_write_n   : m0_write_n;
    sel_writedata_d = grant_idx ? m1_writedata : m0_writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      grant_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      pio_address_q    <= '0;
      pio_chipselect_q <= 1'b0;
      pio_write_n_q    <= 1'b1;
      pio_writedata_q  <= '0;
      m0_readdata_q    <= '0;
      m1_readdata_q    <= '0;
      cnt_q            <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((&req) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (grant_valid) begin
            state_q          <= ST_ACCESS;
            grant_q          <= grant_idx;
            last_grant_q     <= grant_idx;
            pio_address_q    <= sel_address_d;
            pio_write_n_q    <= sel_write_n_d;
            pio_writedata_q  <= sel_writedata_d;
            pio_chipselect_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          state_q          <= ST_DONE;
          pio_chipselect_q <= 1'b0;
          pio_write_n_q    <= 1'b1;
          // pio_write_n_q still holds the strobe of the access just ending.
          if (pio_write_n_q) begin
            if (grant_q) begin
              m1_readdata_q <= pio_readdata;
            end else begin
              m0_readdata_q <= pio_readdata;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_waitrequest = m0_chipselect & ~((state_q == ST_DONE) && !grant_q);
  assign m1_waitrequest = m1_chipselect & ~((state_q == ST_DONE) &&  grant_q);

  assign pio_address    = pio_address_q;
  assign pio_chipselect = pio_chipselect_q;
  assign pio_write_n    = pio_write_n_q;
  assign pio_writedata  = pio_writedata_q;
  assign m0_readdata    = m0_readdata_q;
  assign m1_readdata    = m1_readdata_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_soc_system_pio_arbiter.sv
// Directed bench for soc_system_pio_arbiter: a per-cycle vector table
// followed by hand-written reset-abort and counter-saturation sequences.
module tb_soc_system_pio_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m0_a = '0, m1_a = '0;
  logic        m0_cs = 1'b0, m1_cs = 1'b0;
  logic        m0_wn = 1'b1, m1_wn = 1'b1;
  logic [31:0] m0_wd = '0, m1_wd = '0;
  logic [31:0] m0_rd, m1_rd;
  logic        m0_wr, m1_wr;
  logic [1:0]  p_a;
  logic        p_cs, p_wn;
  logic [31:0] p_wd;
  logic [31:0] p_rd = '0;
  logic [15:0] cnt;

  // Second instance with a 2-bit counter so saturation is reachable quickly.
  logic        s_rst = 1'b1;
  logic        s_cs0 = 1'b0, s_cs1 = 1'b0;
  logic [1:0]  s_a = 2'd0;
  logic        s_wn = 1'b0;
  logic [31:0] s_wd = 32'h0000_0009;
  logic [31:0] s_prd = '0;
  logic [31:0] s_rd0, s_rd1, s_pwd;
  logic        s_wr0, s_wr1, s_pcs, s_pwn;
  logic [1:0]  s_pa;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  soc_system_pio_arbiter dut (
    .clk(clk), .reset(rst),
    .m0_address(m0_a), .m0_chipselect(m0_cs), .m0_write_n(m0_wn),
    .m0_writedata(m0_wd), .m0_readdata(m0_rd), .m0_waitrequest(m0_wr),
    .m1_address(m1_a), .m1_chipselect(m1_cs), .m1_write_n(m1_wn),
    .m1_writedata(m1_wd), .m1_readdata(m1_rd), .m1_waitrequest(m1_wr),
    .pio_address(p_a), .pio_chipselect(p_cs), .pio_write_n(p_wn),
    .pio_writedata(p_wd), .pio_readdata(p_rd), .contention_cnt(cnt)
  );

  soc_system_pio_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(s_rst),
    .m0_address(s_a), .m0_chipselect(s_cs0), .m0_write_n(s_wn),
    .m0_writedata(s_wd), .m0_readdata(s_rd0), .m0_waitrequest(s_wr0),
    .m1_address(s_a), .m1_chipselect(s_cs1), .m1_write_n(s_wn),
    .m1_writedata(s_wd), .m1_readdata(s_rd1), .m1_waitrequest(s_wr1),
    .pio_address(s_pa), .pio_chipselect(s_pcs), .pio_write_n(s_pwn),
    .pio_writedata(s_pwd), .pio_readdata(s_prd), .contention_cnt(s_cnt)
  );

  typedef struct {
    logic        rst;
    logic        cs0, wn0;
    logic [1:0]  a0;
    logic [31:0] wd0;
    logic        cs1, wn1;
    logic [1:0]  a1;
    logic [31:0] wd1;
    logic [31:0] prd;
    logic        e_wr0, e_wr1, e_pcs, e_pwn;
    logic [1:0]  e_pa;
    logic [31:0] e_pwd, e_rd0, e_rd1;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [31:0] r,
    input logic [31:0] c0, input logic [31:0] w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic [31:0] c1, input logic [31:0] w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic [31:0] prd,
    input logic [31:0] wr0, input logic [31:0] wr1, input logic [31:0] pcs, input logic [31:0] pwn,
    input logic [31:0] pa, input logic [31:0] pwd, input logic [31:0] rd0, input logic [31:0] rd1,
    input logic [31:0] ec);
    vec_t v;
    v.rst = r[0];
    v.cs0 = c0[0]; v.wn0 = w0[0]; v.a0 = a0[1:0]; v.wd0 = d0;
    v.cs1 = c1[0]; v.wn1 = w1[0]; v.a1 = a1[1:0]; v.wd1 = d1;
    v.prd = prd;
    v.e_wr0 = wr0[0]; v.e_wr1 = wr1[0]; v.e_pcs = pcs[0]; v.e_pwn = pwn[0];
    v.e_pa = pa[1:0]; v.e_pwd = pwd; v.e_rd0 = rd0; v.e_rd1 = rd1;
    v.e_cnt = ec[15:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp_v);
    end
  endtask

  task automatic apply(input vec_t v);
    rst   = v.rst;
    m0_cs = v.cs0; m0_wn = v.wn0; m0_a = v.a0; m0_wd = v.wd0;
    m1_cs = v.cs1; m1_wn = v.wn1; m1_a = v.a1; m1_wd = v.wd1;
    p_rd  = v.prd;
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk($sformatf("r%0d m0_waitrequest", i), 32'(m0_wr), 32'(v.e_wr0));
    chk($sformatf("r%0d m1_waitrequest", i), 32'(m1_wr), 32'(v.e_wr1));
    chk($sformatf("r%0d pio_chipselect", i), 32'(p_cs), 32'(v.e_pcs));
    chk($sformatf("r%0d pio_write_n", i), 32'(p_wn), 32'(v.e_pwn));
    chk($sformatf("r%0d pio_address", i), 32'(p_a), 32'(v.e_pa));
    chk($sformatf("r%0d pio_writedata", i), p_wd, v.e_pwd);
    chk($sformatf("r%0d m0_readdata", i), m0_rd, v.e_rd0);
    chk($sformatf("r%0d m1_readdata", i), m1_rd, v.e_rd1);
    chk($sformatf("r%0d contention_cnt", i), 32'(cnt), 32'(v.e_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] R1 = 32'h1234_5678;
  localparam logic [31:0] CF = 32'hCAFE_F00D;
  localparam logic [31:0] BF = 32'h0BAD_BEEF;

  initial begin
    // rst | m0 cs,wn,a,wd | m1 cs,wn,a,wd | prd | wr0,wr1,pcs,pwn,pa,pwd,rd0,rd1,cnt
    vq.push_back(mk(1, 0,1,0,0,     0,1,0,0,     0,  0,0,0,1,0,0,    0, 0, 0)); // r0 reset
    vq.push_back(mk(0, 0,1,0,0,     0,1,0,0,     0,  0,0,0,1,0,0,    0, 0, 0));
    vq.push_back(mk(0, 1,0,1,'h11,  1,0,2,'h22,  0,  1,1,0,1,0,0,    0, 0, 0)); // r2 contention
    vq.push_back(mk(0, 1,0,1,'h11,  1,0,2,'h22,  0,  1,1,1,0,1,'h11, 0, 0, 1)); // m0 first
    vq.push_back(mk(0, 1,0,1,'h11,  1,0,2,'h22,  0,  0,1,0,1,1,'h11, 0, 0, 1));
    vq.push_back(mk(0, 0,1,0,0,     1,0,2,'h22,  0,  0,1,0,1,1,'h11, 0, 0, 1));
    vq.push_back(mk(0, 0,1,0,0,     1,0,2,'h22,  0,  0,1,1,0,2,'h22, 0, 0, 1)); // m1 next slot
    vq.push_back(mk(0, 0,1,0,0,     1,0,2,'h22,  0,  0,0,0,1,2,'h22, 0, 0, 1));
    vq.push_back(mk(0, 0,1,0,0,     0,1,0,0,     0,  0,0,0,1,2,'h22, 0, 0, 1));
    vq.push_back(mk(0, 1,0,0,'hA5,  0,1,0,0,     0,  1,0,0,1,2,'h22, 0, 0, 1)); // r9 m0 write A5
    vq.push_back(mk(0, 1,0,0,'hA5,  0,1,0,0,     0,  1,0,1,0,0,'hA5, 0, 0, 1));
    vq.push_back(mk(0, 1,0,0,'hA5,  0,1,0,0,     0,  0,0,0,1,0,'hA5, 0, 0, 1));
    vq.push_back(mk(0, 0,1,0,0,     0,1,0,0,     0,  0,0,0,1,0,'hA5, 0, 0, 1));
    vq.push_back(mk(0, 0,1,0,0,     1,1,0,0,     R1, 0,1,0,1,0,'hA5, 0, 0, 1)); // r13 m1 read
    vq.push_back(mk(0, 0,1,0,0,     1,1,0,0,     R1, 0,1,1,1,0,0,    0, 0, 1));
    vq.push_back(mk(0, 0,1,0,0,     1,1,0,0,     R1, 0,0,0,1,0,0,    0, R1,1));
    vq.push_back(mk(0, 0,1,0,0,     0,1,0,0,     'hDEAD, 0,0,0,1,0,0, 0, R1,1));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  CF, 1,1,0,1,0,0,    0, R1,1)); // r17 continuous
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  CF, 1,1,1,1,3,'h33, 0, R1,2));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  CF, 0,1,0,1,3,'h33, CF,R1,2));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  CF, 1,1,0,1,3,'h33, CF,R1,2));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  CF, 1,1,1,0,1,'h44, CF,R1,3));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  CF, 1,0,0,1,1,'h44, CF,R1,3));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  CF, 1,1,0,1,1,'h44, CF,R1,3));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  BF, 1,1,1,1,3,'h33, CF,R1,4));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  BF, 0,1,0,1,3,'h33, BF,R1,4));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  BF, 1,1,0,1,3,'h33, BF,R1,4));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  BF, 1,1,1,0,1,'h44, BF,R1,5));
    vq.push_back(mk(0, 1,1,3,'h33,  1,0,1,'h44,  BF, 1,0,0,1,1,'h44, BF,R1,5));
    vq.push_back(mk(0, 0,1,0,0,     0,1,0,0,     0,  0,0,0,1,1,'h44, BF,R1,5));
    vq.push_back(mk(0, 1,0,2,'h55,  0,1,0,0,     0,  1,0,0,1,1,'h44, BF,R1,5)); // r30
    vq.push_back(mk(0, 1,0,2,'h55,  1,0,3,'h66,  0,  1,1,1,0,2,'h55, BF,R1,5)); // m1 arrives in ACCESS
    vq.push_back(mk(0, 1,0,2,'h55,  1,0,3,'h66,  0,  0,1,0,1,2,'h55, BF,R1,5));
    vq.push_back(mk(0, 0,1,0,0,     1,0,3,'h66,  0,  0,1,0,1,2,'h55, BF,R1,5));
    vq.push_back(mk(0, 0,1,0,0,     1,0,3,'h66,  0,  0,1,1,0,3,'h66, BF,R1,5));
    vq.push_back(mk(0, 0,1,0,0,     1,0,3,'h66,  0,  0,0,0,1,3,'h66, BF,R1,5));
    vq.push_back(mk(0, 0,1,0,0,     0,1,0,0,     0,  0,0,0,1,3,'h66, BF,R1,5));

    for (int i = 0; i < vq.size(); i++) begin
      step();
      apply(vq[i]);
      @(negedge clk);
      check_row(i, vq[i]);
    end

    // Reset during the ACCESS cycle of an m0 write.
    step();
    m0_cs = 1'b1; m0_wn = 1'b0; m0_a = 2'd1; m0_wd = 32'h77;
    @(negedge clk);
    chk("abort idle wait", 32'(m0_wr), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("abort access pcs", 32'(p_cs), 32'd1);
    chk("abort access wait", 32'(m0_wr), 32'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort rst wait", 32'(m0_wr), 32'd1);
    chk("abort rst pcs", 32'(p_cs), 32'd0);
    chk("abort rst pwn", 32'(p_wn), 32'd1);
    chk("abort rst pa", 32'(p_a), 32'd0);
    chk("abort rst pwd", p_wd, 32'd0);
    chk("abort rst rd0", m0_rd, 32'd0);
    chk("abort rst rd1", m1_rd, 32'd0);
    chk("abort rst cnt", 32'(cnt), 32'd0);
    step();
    @(negedge clk);
    chk("retry access pcs", 32'(p_cs), 32'd1);
    chk("retry access pwd", p_wd, 32'h77);
    chk("retry access pwn", 32'(p_wn), 32'd0);
    chk("retry access wait", 32'(m0_wr), 32'd1);
    step();
    @(negedge clk);
    chk("retry done wait", 32'(m0_wr), 32'd0);
    step();
    m0_cs = 1'b0;
    @(negedge clk);
    chk("retry idle wait", 32'(m0_wr), 32'd0);
    chk("retry idle pcs", 32'(p_cs), 32'd0);

    // Counter saturation on the 2-bit instance: two contended grants bring
    // it to all-ones minus one, three more must leave it at all-ones.
    step();
    s_rst = 1'b0; s_cs0 = 1'b1; s_cs1 = 1'b1;
    @(negedge clk);
    chk("sat rst cnt", 32'(s_cnt), 32'd0);
    chk("sat rst pcs", 32'(s_pcs), 32'd0);
    chk("sat rst pwn", 32'(s_pwn), 32'd1);
    chk("sat rst pa", 32'(s_pa), 32'd0);
    chk("sat rst pwd", s_pwd, 32'd0);
    chk("sat rst rd0", s_rd0, 32'd0);
    chk("sat rst rd1", s_rd1, 32'd0);
    chk("sat idle wait0", 32'(s_wr0), 32'd1);
    chk("sat idle wait1", 32'(s_wr1), 32'd1);
    for (int t = 1; t <= 13; t++) begin
      step();
      @(negedge clk);
      if (t == 4)  chk("sat cnt t4", 32'(s_cnt), 32'd2);
      if (t == 7)  chk("sat cnt t7", 32'(s_cnt), 32'd3);
      if (t == 10) chk("sat cnt t10", 32'(s_cnt), 32'd3);
      if (t == 13) chk("sat cnt t13", 32'(s_cnt), 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
